// File: rtl/sel_pattern_driver.sv
// Line-state sequencer for the single-bit sel net: stores a short pattern of
// 0/1/Z/X codes and replays it with a programmable per-step dwell.
module sel_pattern_driver #(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [1:0]               load_code,
  output logic                     load_ready,
  input  logic                     clear,
  input  logic                     start,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     abort,
  output logic                     sel_o,
  output logic                     sel_oe,
  output logic                     sel_x,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               sel_o_q, sel_o_d;
  logic               sel_oe_q, sel_oe_d;
  logic               sel_x_q, sel_x_d;
  logic               mem_we;
  logic               last_entry;
  logic [1:0]         code_sel;
  logic [1:0]         mem_q [DEPTH];

  assign load_ready = (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
  assign last_entry = ({1'b0, step_idx_q} == (count_q - CNT_W'(1)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    step_idx_d  = step_idx_q;
    dwell_lat_d = dwell_lat_q;
    dwell_cnt_d = dwell_cnt_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (load_valid && load_ready) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
        // The start decision sees the buffer after this cycle's write/clear.
        if (start) begin
          if (count_d != '0) begin
            state_d     = S_RUN;
            dwell_lat_d = dwell;
            dwell_cnt_d = '0;
            step_idx_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dwell_cnt_q == dwell_lat_q) begin
          if (last_entry) begin
            state_d = S_DONE;
          end else begin
            step_idx_d  = step_idx_q + IDX_W'(1);
            dwell_cnt_d = '0;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_RUN) step_idx_d = '0;

    // Bypass the buffer when the entry to drive is being written this cycle.
    if (mem_we && ({1'b0, step_idx_d} == count_q)) code_sel = load_code;
    else                                           code_sel = mem_q[step_idx_d];

    sel_oe_d = 1'b0;
    sel_o_d  = 1'b0;
    sel_x_d  = 1'b0;
    if (state_d == S_RUN) begin
      case (code_sel)
        2'b00:   sel_oe_d = 1'b1;
        2'b01:   begin sel_oe_d = 1'b1; sel_o_d = 1'b1; end
        2'b10:   sel_oe_d = 1'b0;
        default: begin sel_oe_d = 1'b1; sel_x_d = 1'b1; end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      step_idx_q  <= '0;
      dwell_lat_q <= '0;
      dwell_cnt_q <= '0;
      sel_o_q     <= 1'b0;
      sel_oe_q    <= 1'b0;
      sel_x_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_idx_q  <= step_idx_d;
      dwell_lat_q <= dwell_lat_d;
      dwell_cnt_q <= dwell_cnt_d;
      sel_o_q     <= sel_o_d;
      sel_oe_q    <= sel_oe_d;
      sel_x_q     <= sel_x_d;
    end
  end

  // NOTE: the pattern storage is deliberately not reset; count_q alone
  // defines which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[IDX_W-1:0]] <= load_code;
  end

  assign sel_o    = sel_o_q;
  assign sel_oe   = sel_oe_q;
  assign sel_x    = sel_x_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign step_idx = step_idx_q;
  assign count    = count_q;

endmodule
